sample_agc: RTL

Streaming automatic-gain stage for packed complex samples. Each valid sample is {re, im}, two signed WIDTH/2-bit halves. The stage applies a runtime-selected arithmetic right shift to each sample and adapts that shift once per window of samples from the observed peak magnitude. It sits directly upstream of the fixed one-bit width-reduction stage, so samples reach that stage with headroom that is bounded and known.

---
 rtl/sample_agc.sv | 119 +++++++++++
 1 files changed

// File: rtl/sample_agc.sv
// rtl/sample_agc.sv - streaming complex-sample AGC with windowed peak-driven shift
//
// Ports:
//   clk        in   1            rising-edge clock
//   rst_n      in   1            asynchronous active-low reset
//   in_data    in   WIDTH        packed {re, im} signed sample
//   in_nd      in   1            in_data valid
//   hold       in   1            suppress shift update at window end
//   out_data   out  WIDTH        packed {re>>>shift, im>>>shift}
//   out_nd     out  1            out_data valid (one cycle after in_nd)
//   out_shift  out  SHIFT_WIDTH  shift applied to incoming samples

module sample_agc #(
  parameter int WIDTH       = 32,
  parameter int WINDOW_LOG  = 8,
  parameter int SHIFT_WIDTH = 3,
  parameter int MAX_SHIFT   = 7,
  parameter int INIT_SHIFT  = 0
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [WIDTH-1:0]       in_data,
  input  logic                   in_nd,
  input  logic                   hold,
  output logic [WIDTH-1:0]       out_data,
  output logic                   out_nd,
  output logic [SHIFT_WIDTH-1:0] out_shift
);

  localparam int N = WIDTH / 2;

  // Peak thresholds: grow the shift when the top two magnitude bits are in
  // use, shrink it when the top four are idle.
  localparam logic [N-1:0] HI_THR  = N'(2 ** (N - 2));
  localparam logic [N-1:0] LO_THR  = N'(2 ** (N - 4));
  localparam logic [N-1:0] SAT_MAG = {1'b0, {(N-1){1'b1}}};

  localparam logic [SHIFT_WIDTH-1:0] MAX_S  = SHIFT_WIDTH'(MAX_SHIFT);
  localparam logic [SHIFT_WIDTH-1:0] INIT_S = SHIFT_WIDTH'(INIT_SHIFT);

  logic [SHIFT_WIDTH-1:0] shift_q, shift_d;
  logic [WINDOW_LOG-1:0]  count_q, count_d;
  logic [N-1:0]           peak_q, peak_d;
  logic [WIDTH-1:0]       out_data_q, out_data_d;
  logic                   out_nd_q, out_nd_d;

  logic signed [N-1:0] re_raw, im_raw, s_re, s_im;
  logic [N-1:0]        mag_re, mag_im, mag, pk;
  logic                end_win;

  // |v| with the most negative value saturating to the largest positive one.
  function automatic logic [N-1:0] mag_of(input logic signed [N-1:0] v);
    if (!v[N-1]) begin
      return v;
    end else if (~|v[N-2:0]) begin
      return SAT_MAG;
    end else begin
      return -v;
    end
  endfunction

  always_comb begin
    re_raw = in_data[WIDTH-1:N];
    im_raw = in_data[N-1:0];
    s_re   = re_raw >>> shift_q;
    s_im   = im_raw >>> shift_q;
    mag_re = mag_of(s_re);
    mag_im = mag_of(s_im);
    mag    = (mag_re > mag_im) ? mag_re : mag_im;
    // Window peak including the current sample, so the last sample counts.
    pk     = (mag > peak_q) ? mag : peak_q;
    end_win = in_nd && (count_q == '1);
  end

  always_comb begin
    shift_d    = shift_q;
    count_d    = count_q;
    peak_d     = peak_q;
    out_data_d = out_data_q;
    out_nd_d   = in_nd;

    if (in_nd) begin
      out_data_d = {s_re, s_im};
      count_d    = count_q + 1'b1;   // wraps to 0 at window end
      peak_d     = pk;
      if (end_win) begin
        peak_d = '0;
        if (!hold) begin
          if (pk >= HI_THR && shift_q < MAX_S) begin
            shift_d = shift_q + 1'b1;
          end else if (pk < LO_THR && shift_q != '0) begin
            shift_d = shift_q - 1'b1;
          end
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shift_q    <= INIT_S;
      count_q    <= '0;
      peak_q     <= '0;
      out_data_q <= '0;
      out_nd_q   <= 1'b0;
    end else begin
      shift_q    <= shift_d;
      count_q    <= count_d;
      peak_q     <= peak_d;
      out_data_q <= out_data_d;
      out_nd_q   <= out_nd_d;
    end
  end

  assign out_data  = out_data_q;
  assign out_nd    = out_nd_q;
  assign out_shift = shift_q;

endmodule
